alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Registered, handshaked ALU control stage for the pipelined CPU's EX stage. Decodes ALU op into
//  adder/mux selects (cout_sel, sum_sel, sub) and adds an iterative shift op (1 beat per STEP bits).
//  Sits between ID/EX pipeline register and ALU datapath; stalls upstream while a shift iterates.
// PARAMETERS
//  WIDTH    64              datapath width; bounds shift amount
//  SHAMT_W  $clog2(WIDTH)   width of shamt input
//  STEP     1               bits shifted per iteration beat; power of 2, 1..WIDTH
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-high reset
//  in_valid   in   1        op/shamt valid
//  in_ready   out  1        stage can accept op
//  cntrl      in   3        ALU op code
//  shamt      in   SHAMT_W  shift amount (used only for op 3'b111)
//  out_valid  out  1        select beat valid
//  out_ready  in   1        ALU consumes beat
//  cout_sel   out  1        carry-out select
//  sum_sel    out  2        result mux select {sum_sel1,sum_sel0}
//  sub        out  1        invert B / carry-in=1
//  shift_en   out  1        ALU performs one STEP-bit left shift this beat
//  last       out  1        final beat of current op
//  illegal_op out  1        only with ALU_OPSEQ_TRAP_EN (tied 0 otherwise)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, iteration counter 0; in_ready=0 while reset high.
//  Decode (cntrl -> cout_sel,sum_sel,sub): 000 PASSB ->0,10,0; 010 ADD ->1,11,0; 011 SUB ->1,11,1;
//   100 AND ->0,00,0; 101 OR ->0,01,0; 110 XOR ->0,11,0; 111 SHL ->0,10,0 with shift_en=1.
//  Handshake: transfer on valid&ready at rising edge. out_* regs hold stable while out_valid&!out_ready.
//  in_ready = (state==IDLE) & (!out_valid | out_ready)  (combinational; no skid buffer).
//  Latency: accepted single-cycle op appears on out_* next cycle, last=1, shift_en=0.
//  FSM: IDLE, SHIFT.
//   IDLE: accept op. Non-shift or shamt==0 -> load decode, last=1, stay IDLE (shamt==0 SHL = PASSB).
//         SHL with shamt>0 -> beats N=ceil(shamt/STEP); load beat1 (shift_en=1, last=(N==1));
//         if N>1 -> SHIFT with remaining=N-1.
//   SHIFT: in_ready=0. On each out handshake emit next beat, remaining-1; beat with remaining==1
//         carries last=1; after last beat accepted -> IDLE (new op accepted same cycle allowed).
//  Counter width SHAMT_W+1; no wrap: shamt=WIDTH-1, STEP=1 -> WIDTH-1 beats exactly.
//  out_valid drops to 0 when a beat is consumed and no new op/beat is loaded.
//  Backpressure mid-shift: counter frozen, outputs held, no beat lost or duplicated.
//  Reset mid-SHIFT: aborts immediately (async); after release IDLE, no residual beats.
//  Simultaneous: out handshake of last beat + in handshake same edge -> new op loaded, no bubble.
// CONFIGURATION
//  ALU_OPSEQ_TRAP_EN defined: cntrl=001 accepted, produces one beat with all selects 0,
//   shift_en=0, last=1, illegal_op=1 (illegal_op valid only with out_valid).
//  Undefined: cntrl=001 decodes as PASSB (0,10,0); illegal_op port tied 0.
// TESTING
//  ADD then SUB back-to-back, out_ready=1 -> beats (1,11,0,last=1) then (1,11,1,last=1), no bubble.
//  AND with out_ready=0 for 3 cycles -> out_valid=1 held (0,00,0), in_ready=0 until accepted.
//  SHL shamt=5, STEP=1 -> 5 beats shift_en=1, last only on 5th, in_ready=0 for beats 1-4;
//   STEP=4 -> 2 beats.
//  SHL shamt=0 -> single beat PASSB, shift_en=0, last=1.
//  SHL shamt=6, out_ready toggling 1,0,1,0 -> exactly 6 beats, outputs stable while stalled.
//  Reset at beat 3 of SHL shamt=8 -> outputs 0 during reset; after release in_ready=1, no beats.
//  cntrl=001: with ALU_OPSEQ_TRAP_EN -> illegal_op=1, selects 0; without -> (0,10,0).

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// ALU op sequencer handshake bundle: op request side and select-beat side.
// master drives ops and consumes beats; slave is the sequencer.
interface alu_op_sequencer_if #(
  parameter int SHAMT_W = 6
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         cntrl;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic               cout_sel;
  logic [1:0]         sum_sel;
  logic               sub;
  logic               shift_en;
  logic               last;
  logic               illegal_op;

  modport master (
    output in_valid, cntrl, shamt, out_ready,
    input  in_ready, out_valid, cout_sel, sum_sel,
    input  sub, shift_en, last, illegal_op
  );

  modport slave (
    input  in_valid, cntrl, shamt, out_ready,
    output in_ready, out_valid, cout_sel, sum_sel,
    output sub, shift_en, last, illegal_op
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU select sequencer for the EX stage; SHL iterates STEP bits per beat.
// Define ALU_OPSEQ_TRAP_EN to trap cntrl=001 as an illegal op.
module alu_op_sequencer #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 1
) (
  input  logic clk,
  input  logic reset,
  alu_op_sequencer_if.slave bus
);

  localparam int CNT_W    = SHAMT_W + 1;
  localparam int LOG_STEP = $clog2(STEP);
  localparam logic [CNT_W-1:0] STEP_M1 = CNT_W'(STEP - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic [CNT_W-1:0] beats;
  logic             ov, ov_nxt;
  logic             cs, cs_nxt;
  logic [1:0]       ss, ss_nxt;
  logic             sb, sb_nxt;
  logic             se, se_nxt;
  logic             lst, lst_nxt;
  logic             in_fire;
  logic             out_fire;
`ifdef ALU_OPSEQ_TRAP_EN
  logic             il, il_nxt;
`endif

  // Accept only when idle and the output slot is free or draining.
  assign bus.in_ready = !reset && (state == IDLE) &&
                        (!ov || bus.out_ready);
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = ov && bus.out_ready;

  // Shift beats = ceil(shamt / STEP); extra MSB keeps the sum from wrapping.
  assign beats = ({1'b0, bus.shamt} + STEP_M1) >> LOG_STEP;

  assign bus.out_valid = ov;
  assign bus.cout_sel  = cs;
  assign bus.sum_sel   = ss;
  assign bus.sub       = sb;
  assign bus.shift_en  = se;
  assign bus.last      = lst;
`ifdef ALU_OPSEQ_TRAP_EN
  assign bus.illegal_op = il;
`else
  assign bus.illegal_op = 1'b0;
`endif

  // State and output beat registers; reset aborts any shift in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rem   <= '0;
      ov    <= 1'b0;
      cs    <= 1'b0;
      ss    <= 2'b00;
      sb    <= 1'b0;
      se    <= 1'b0;
      lst   <= 1'b0;
`ifdef ALU_OPSEQ_TRAP_EN
      il    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      ov    <= ov_nxt;
      cs    <= cs_nxt;
      ss    <= ss_nxt;
      sb    <= sb_nxt;
      se    <= se_nxt;
      lst   <= lst_nxt;
`ifdef ALU_OPSEQ_TRAP_EN
      il    <= il_nxt;
`endif
    end
  end

  // Next beat: load a new op, advance a shift, drain, or hold.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    ov_nxt    = ov;
    cs_nxt    = cs;
    ss_nxt    = ss;
    sb_nxt    = sb;
    se_nxt    = se;
    lst_nxt   = lst;
`ifdef ALU_OPSEQ_TRAP_EN
    il_nxt    = il;
`endif
    if (in_fire) begin
      ov_nxt    = 1'b1;
      cs_nxt    = 1'b0;
      ss_nxt    = 2'b10;
      sb_nxt    = 1'b0;
      se_nxt    = 1'b0;
      lst_nxt   = 1'b1;
      rem_nxt   = '0;
      state_nxt = IDLE;
`ifdef ALU_OPSEQ_TRAP_EN
      il_nxt    = 1'b0;
`endif
      case (bus.cntrl)
        3'b001: begin
`ifdef ALU_OPSEQ_TRAP_EN
          ss_nxt = 2'b00;
          il_nxt = 1'b1;
`else
          ss_nxt = 2'b10;
`endif
        end
        3'b010: begin
          cs_nxt = 1'b1;
          ss_nxt = 2'b11;
        end
        3'b011: begin
          cs_nxt = 1'b1;
          ss_nxt = 2'b11;
          sb_nxt = 1'b1;
        end
        3'b100: ss_nxt = 2'b00;
        3'b101: ss_nxt = 2'b01;
        3'b110: ss_nxt = 2'b11;
        3'b111: begin
          if (bus.shamt != '0) begin
            se_nxt  = 1'b1;
            lst_nxt = (beats == ONE);
            rem_nxt = beats - ONE;
            if (beats > ONE) state_nxt = SHIFT;
          end
        end
        default: ss_nxt = 2'b10;
      endcase
    end else if (state == SHIFT && out_fire) begin
      cs_nxt  = 1'b0;
      ss_nxt  = 2'b10;
      sb_nxt  = 1'b0;
      se_nxt  = 1'b1;
      lst_nxt = (rem == ONE);
      rem_nxt = rem - ONE;
      if (rem == ONE) state_nxt = IDLE;
    end else if (out_fire) begin
      ov_nxt  = 1'b0;
      cs_nxt  = 1'b0;
      ss_nxt  = 2'b00;
      sb_nxt  = 1'b0;
      se_nxt  = 1'b0;
      lst_nxt = 1'b0;
`ifdef ALU_OPSEQ_TRAP_EN
      il_nxt  = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: decode table plus
// multi-cycle shift, backpressure and reset sequences (STEP=1 and STEP=4).
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.SHAMT_W(6)) b1 ();
  alu_op_sequencer_if #(.SHAMT_W(6)) b4 ();

  alu_op_sequencer #(.WIDTH(64), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave)
  );
  alu_op_sequencer #(.WIDTH(64), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4.slave)
  );

  typedef struct {
    logic [2:0] c;
    logic [5:0] sh;
    logic [5:0] exp;
    logic       ill;
  } vec_t;

  vec_t tv[8];

  function automatic logic [5:0] sel1();
    return {b1.cout_sel, b1.sum_sel, b1.sub, b1.shift_en, b1.last};
  endfunction

  function automatic logic [5:0] sel4();
    return {b4.cout_sel, b4.sum_sel, b4.sub, b4.shift_en, b4.last};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [2:0] c,
                        input logic [5:0] s, input logic r);
    b1.in_valid = v; b1.cntrl = c; b1.shamt = s; b1.out_ready = r;
    b4.in_valid = v; b4.cntrl = c; b4.shamt = s; b4.out_ready = r;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n1, n4, nl, lpos, fires;
    logic held, rdy;
    logic [5:0] saved;

    tv[0] = '{3'b000, 6'd0, 6'b010001, 1'b0};
    tv[1] = '{3'b010, 6'd0, 6'b111001, 1'b0};
    tv[2] = '{3'b011, 6'd0, 6'b111101, 1'b0};
    tv[3] = '{3'b100, 6'd0, 6'b000001, 1'b0};
    tv[4] = '{3'b101, 6'd0, 6'b001001, 1'b0};
    tv[5] = '{3'b110, 6'd0, 6'b011001, 1'b0};
    tv[6] = '{3'b111, 6'd0, 6'b010001, 1'b0};
`ifdef ALU_OPSEQ_TRAP_EN
    tv[7] = '{3'b001, 6'd0, 6'b000001, 1'b1};
`else
    tv[7] = '{3'b001, 6'd0, 6'b010001, 1'b0};
`endif

    set_in(1'b0, 3'b000, 6'd0, 1'b0);
    cyc();
    cyc();
    chk("rst_valid", b1.out_valid, 0);
    chk("rst_sel", sel1(), 0);
    chk("rst_in_ready", b1.in_ready, 0);
    chk("rst_ill", b1.illegal_op, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", b1.in_ready, 1);

    // Decode table, back-to-back with out_ready high: no bubbles.
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, tv[i].c, tv[i].sh, 1'b1);
      #1;
      chk($sformatf("tv%0d_in_ready", i), b1.in_ready, 1);
      cyc();
      chk($sformatf("tv%0d_valid", i), b1.out_valid, 1);
      chk($sformatf("tv%0d_sel", i), sel1(), tv[i].exp);
      chk($sformatf("tv%0d_ill", i), b1.illegal_op, tv[i].ill);
      chk($sformatf("tv%0d_sel4", i), sel4(), tv[i].exp);
    end
    set_in(1'b0, 3'b000, 6'd0, 1'b1);
    cyc();
    chk("drain_valid", b1.out_valid, 0);

    // AND held under backpressure for 3 cycles.
    set_in(1'b1, 3'b100, 6'd0, 1'b0);
    #1;
    chk("and_in_ready", b1.in_ready, 1);
    cyc();
    set_in(1'b0, 3'b100, 6'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("and_hold%0d_valid", k), b1.out_valid, 1);
      chk($sformatf("and_hold%0d_sel", k), sel1(), 6'b000001);
      chk($sformatf("and_hold%0d_in_ready", k), b1.in_ready, 0);
      cyc();
    end
    set_in(1'b0, 3'b100, 6'd0, 1'b1);
    #1;
    chk("and_release_in_ready", b1.in_ready, 1);
    cyc();
    chk("and_done_valid", b1.out_valid, 0);

    // SHL 5: 5 beats at STEP=1, 2 at STEP=4; ADD follows with no bubble.
    set_in(1'b1, 3'b111, 6'd5, 1'b1);
    cyc();
    set_in(1'b0, 3'b000, 6'd0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) set_in(1'b1, 3'b010, 6'd0, 1'b1);
      #1;
      chk($sformatf("shl5_b%0d_valid", k), b1.out_valid, 1);
      chk($sformatf("shl5_b%0d_sel", k), sel1(),
          {1'b0, 2'b10, 1'b0, 1'b1, (k == 5)});
      chk($sformatf("shl5_b%0d_in_ready", k), b1.in_ready, (k == 5));
      chk($sformatf("shl5s4_b%0d_valid", k), b4.out_valid, (k <= 2));
      if (k <= 2)
        chk($sformatf("shl5s4_b%0d_sel", k), sel4(),
            {1'b0, 2'b10, 1'b0, 1'b1, (k == 2)});
      cyc();
    end
    chk("shl5_next_add", sel1(), 6'b111001);
    chk("shl5_next_add_s4", sel4(), 6'b111001);
    set_in(1'b0, 3'b000, 6'd0, 1'b1);
    cyc();
    chk("shl5_idle_valid", b1.out_valid, 0);

    // SHL 6 with out_ready toggling: 6 beats, held while stalled.
    set_in(1'b1, 3'b111, 6'd6, 1'b1);
    cyc();
    set_in(1'b0, 3'b000, 6'd0, 1'b0);
    fires = 0; nl = 0; lpos = 0; held = 1'b0; saved = '0;
    for (int i = 0; i < 40 && fires < 6; i++) begin
      if (held) chk($sformatf("shl6_hold%0d", i), sel1(), saved);
      rdy = (i % 2 == 0);
      b1.out_ready = rdy;
      b4.out_ready = rdy;
      if (b1.out_valid && rdy) begin
        fires++;
        chk($sformatf("shl6_f%0d_shift_en", fires), b1.shift_en, 1);
        if (b1.last) begin
          nl++;
          lpos = fires;
        end
      end
      held = b1.out_valid && !rdy;
      saved = sel1();
      cyc();
    end
    chk("shl6_beats", fires, 6);
    chk("shl6_last_count", nl, 1);
    chk("shl6_last_pos", lpos, 6);
    b1.out_ready = 1'b1;
    b4.out_ready = 1'b1;
    #1;
    chk("shl6_idle_valid", b1.out_valid, 0);

    // SHL WIDTH-1: 63 beats at STEP=1, 16 at STEP=4.
    cyc();
    set_in(1'b1, 3'b111, 6'd63, 1'b1);
    cyc();
    set_in(1'b0, 3'b000, 6'd0, 1'b1);
    n1 = 0; n4 = 0; nl = 0;
    for (int i = 0; i < 80; i++) begin
      if (b1.out_valid) n1++;
      if (b1.out_valid && b1.last) nl++;
      if (b4.out_valid) n4++;
      cyc();
    end
    chk("shl63_beats", n1, 63);
    chk("shl63_last_count", nl, 1);
    chk("shl63_beats_s4", n4, 16);

    // Reset at beat 3 of SHL 8: abort, no residual beats.
    set_in(1'b1, 3'b111, 6'd8, 1'b1);
    cyc();
    set_in(1'b0, 3'b000, 6'd0, 1'b1);
    cyc();
    cyc();
    chk("shl8_b3_sel", sel1(), 6'b010010);
    reset = 1'b1;
    #1;
    chk("shl8_rst_valid", b1.out_valid, 0);
    chk("shl8_rst_sel", sel1(), 0);
    chk("shl8_rst_in_ready", b1.in_ready, 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("shl8_post_in_ready", b1.in_ready, 1);
    n1 = 0;
    for (int i = 0; i < 12; i++) begin
      if (b1.out_valid) n1++;
      cyc();
    end
    chk("shl8_residual", n1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
